// File: rtl/bias_relu_layer14.sv
// bias_relu_layer14: per-lane post-accumulation stage for layer 14.
// Accumulates N_PASS partial-sum vectors from the adder tree, adds the
// per-channel bias, applies optional ReLU, saturates to DW bits and hands
// one result vector downstream over a valid/ready handshake.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    partial-sum vector handshake (in_ready is combinational)
//   in_data              N_adder_tree lanes of DW-bit signed partial sums
//   bias                 N_adder_tree lanes of DW-bit signed bias (sampled in FINISH)
//   out_valid/out_ready  result vector handshake
//   out_data             N_adder_tree lanes of DW-bit saturated results
//   pass_cnt             partial sums accepted for the vector in progress
module bias_relu_layer14 #(
  parameter int unsigned N_adder_tree = 16,
  parameter int unsigned DW           = 18,
  parameter int unsigned ACC_W        = 24,
  parameter int unsigned N_PASS       = 4,
  parameter bit          RELU_EN      = 1'b1,
  localparam int unsigned PCW         = (N_PASS > 1) ? $clog2(N_PASS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_adder_tree*DW-1:0] in_data,
  input  logic [N_adder_tree*DW-1:0] bias,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_adder_tree*DW-1:0] out_data,
  output logic [PCW-1:0]             pass_cnt
);

  // Bias add is done one bit wider than the accumulator so it never wraps.
  localparam int unsigned SW = ACC_W + 1;
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    FINISH = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t                     state;
  logic                       fire;
  logic                       first_pass;
  logic                       last_pass;
  logic [N_adder_tree*DW-1:0] res;

  assign in_ready   = (state == ACCUM);
  assign fire       = in_valid && in_ready;
  assign first_pass = (pass_cnt == '0);
  assign last_pass  = (pass_cnt == PCW'(N_PASS - 1));

  // Independent per-lane accumulator and bias/ReLU/saturate datapath.
  for (genvar k = 0; k < N_adder_tree; k++) begin : g_lane
    logic signed [DW-1:0]    in_lane;
    logic signed [DW-1:0]    bias_lane;
    logic signed [DW-1:0]    sat;
    logic signed [ACC_W-1:0] in_ext;
    logic signed [ACC_W-1:0] acc;
    logic signed [SW-1:0]    sum;
    logic signed [SW-1:0]    rel;

    assign in_lane   = in_data[DW*k +: DW];
    assign bias_lane = bias[DW*k +: DW];
    assign in_ext    = {{(ACC_W-DW){in_lane[DW-1]}}, in_lane};
    assign sum       = {acc[ACC_W-1], acc} + {{(SW-DW){bias_lane[DW-1]}}, bias_lane};

    // ReLU first, then clamp into the DW-bit signed range.
    always_comb begin
      rel = sum;
      if (RELU_EN && sum[SW-1]) begin
        rel = '0;
      end
      sat = rel[DW-1:0];
      if (rel > SAT_MAX) begin
        sat = SAT_MAX[DW-1:0];
      end else if (rel < SAT_MIN) begin
        sat = SAT_MIN[DW-1:0];
      end
    end

    // First pass of a vector overwrites, later passes accumulate.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc <= '0;
      end else if (fire) begin
        acc <= first_pass ? in_ext : acc + in_ext;
      end
    end

    assign res[DW*k +: DW] = sat;
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      pass_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (fire) begin
            if (last_pass) begin
              pass_cnt <= '0;
              state    <= FINISH;
            end else begin
              pass_cnt <= pass_cnt + PCW'(1);
            end
          end
        end
        FINISH: begin
          out_data  <= res;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: begin
          state <= ACCUM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bias_relu_layer14.sv
// Self-checking bench for bias_relu_layer14. Two instances share all inputs:
// one with ReLU enabled, one without, so both behaviours are checked together.
module tb_bias_relu_layer14;

  localparam int unsigned N   = 16;
  localparam int unsigned DW  = 18;
  localparam int unsigned NP  = 4;
  localparam int unsigned W   = N * DW;
  localparam int unsigned PCW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           out_ready;
  logic [W-1:0]   in_data;
  logic [W-1:0]   bias;
  logic           in_ready, in_ready_nr;
  logic           out_valid, out_valid_nr;
  logic [W-1:0]   out_data, out_data_nr;
  logic [PCW-1:0] pass_cnt, pass_cnt_nr;

  int     checks = 0;
  int     errors = 0;
  longint ref_sum[N];

  always #5 clk = ~clk;

  bias_relu_layer14 #(.N_adder_tree(N), .DW(DW), .ACC_W(24), .N_PASS(NP), .RELU_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .bias(bias), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .pass_cnt(pass_cnt)
  );

  bias_relu_layer14 #(.N_adder_tree(N), .DW(DW), .ACC_W(24), .N_PASS(NP), .RELU_EN(1'b0)) dut_nr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_nr),
    .in_data(in_data), .bias(bias), .out_valid(out_valid_nr), .out_ready(out_ready),
    .out_data(out_data_nr), .pass_cnt(pass_cnt_nr)
  );

  // Reference: exact integer sum of passes plus bias, optional ReLU, clamp.
  function automatic logic [W-1:0] model(input logic [W-1:0] b, input bit relu);
    logic [W-1:0] r;
    longint s;
    longint hi;
    hi = (longint'(1) <<< (DW - 1)) - 1;
    r = '0;
    for (int k = 0; k < N; k++) begin
      s = ref_sum[k] + longint'($signed(b[DW*k +: DW]));
      if (relu && s < 0) s = 0;
      if (s > hi) s = hi;
      else if (s < -hi - 1) s = -hi - 1;
      r[DW*k +: DW] = DW'(s);
    end
    return r;
  endfunction

  function automatic int lane(input logic [W-1:0] v, input int k);
    return int'($signed(v[DW*k +: DW]));
  endfunction

  function automatic logic [W-1:0] rep(input int v);
    logic [W-1:0] r;
    for (int k = 0; k < N; k++) r[DW*k +: DW] = DW'(v);
    return r;
  endfunction

  // Mix of full-range and small values so both saturating and exact results occur.
  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] r;
    for (int k = 0; k < N; k++) begin
      if ($urandom_range(0, 1) == 1) r[DW*k +: DW] = DW'($urandom());
      else r[DW*k +: DW] = DW'(int'($urandom_range(0, 4000)) - 2000);
    end
    return r;
  endfunction

  task automatic clear_ref();
    for (int k = 0; k < N; k++) ref_sum[k] = 0;
  endtask

  // Present one pass at a negedge and return at the negedge after it is accepted.
  task automatic feed(input logic [W-1:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL feed_timeout in_ready=%0b expected 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < N; k++) ref_sum[k] += longint'($signed(d[DW*k +: DW]));
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; bias = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b expected 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h expected 0", out_data); end
    checks++; if (pass_cnt !== '0) begin errors++; $display("FAIL reset_pass_cnt got %0d expected 0", pass_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b expected 1", in_ready); end
  endtask

  task automatic test_basic();
    logic [W-1:0] b;
    b = '0;
    b[0 +: DW]  = DW'(5596);
    b[DW +: DW] = DW'(-336);
    clear_ref();
    bias = b;
    for (int i = 0; i < NP; i++) feed(rep(100));
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_latency_early out_valid=%0b expected 0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency out_valid=%0b expected 1", out_valid); end
    checks++; if (lane(out_data, 0) !== 5996) begin errors++; $display("FAIL basic_lane0 got %0d expected 5996", lane(out_data, 0)); end
    checks++; if (lane(out_data, 1) !== 64) begin errors++; $display("FAIL basic_lane1 got %0d expected 64", lane(out_data, 1)); end
    checks++; if (lane(out_data, 7) !== 400) begin errors++; $display("FAIL basic_lane7 got %0d expected 400", lane(out_data, 7)); end
    checks++; if (out_data !== model(b, 1'b1)) begin errors++; $display("FAIL basic_vec got %h expected %h", out_data, model(b, 1'b1)); end
    drain();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL basic_drain out_valid=%0b in_ready=%0b expected 0/1", out_valid, in_ready); end
  endtask

  task automatic test_relu();
    logic [W-1:0] d, b;
    int cyc;
    d = '0; b = '0;
    d[0 +: DW] = DW'(-1000);
    b[0 +: DW] = DW'(500);
    clear_ref();
    bias = b;
    for (int i = 0; i < NP; i++) feed(d);
    wait_valid(cyc);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL relu_latency cycles=%0d expected 1", cyc); end
    checks++; if (lane(out_data, 0) !== 0) begin errors++; $display("FAIL relu_on_lane0 got %0d expected 0", lane(out_data, 0)); end
    checks++; if (lane(out_data_nr, 0) !== -3500) begin errors++; $display("FAIL relu_off_lane0 got %0d expected -3500", lane(out_data_nr, 0)); end
    drain();
  endtask

  task automatic test_saturation();
    int cyc;
    clear_ref();
    bias = rep(131071);
    for (int i = 0; i < NP; i++) feed(rep(131071));
    wait_valid(cyc);
    checks++; if (out_data !== rep(131071)) begin errors++; $display("FAIL sat_pos_relu got %h expected %h", out_data, rep(131071)); end
    checks++; if (out_data_nr !== rep(131071)) begin errors++; $display("FAIL sat_pos_norelu got %h expected %h", out_data_nr, rep(131071)); end
    drain();
    clear_ref();
    bias = rep(-131072);
    for (int i = 0; i < NP; i++) feed(rep(-131072));
    wait_valid(cyc);
    checks++; if (out_data_nr !== rep(-131072)) begin errors++; $display("FAIL sat_neg_norelu got %h expected %h", out_data_nr, rep(-131072)); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL sat_neg_relu got %h expected 0", out_data); end
    drain();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] exp_v, b;
    int cyc;
    clear_ref();
    b = rand_vec();
    bias = b;
    for (int i = 0; i < NP; i++) feed(rand_vec());
    exp_v = model(b, 1'b1);
    wait_valid(cyc);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL bp_latency cycles=%0d expected 1", cyc); end
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = rand_vec();
      bias     = rand_vec();
      @(negedge clk);
      checks++;
      if (out_data !== exp_v || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d out_data=%h in_ready=%0b out_valid=%0b expected %h/0/1", i, out_data, in_ready, out_valid, exp_v);
      end
    end
    in_valid = 1'b0;
    drain();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || pass_cnt !== '0) begin errors++; $display("FAIL bp_release out_valid=%0b in_ready=%0b pass_cnt=%0d expected 0/1/0", out_valid, in_ready, pass_cnt); end
    clear_ref();
    bias = '0;
    for (int i = 0; i < NP; i++) feed(rep(10));
    wait_valid(cyc);
    checks++; if (out_data !== rep(40)) begin errors++; $display("FAIL bp_next_vec got %h expected %h", out_data, rep(40)); end
    drain();
  endtask

  task automatic test_bubbles();
    bit pat[7] = '{1, 0, 0, 1, 0, 1, 1};
    logic [W-1:0] b, d;
    int fires, cyc;
    fires = 0;
    clear_ref();
    b = rand_vec();
    bias = b;
    for (int i = 0; i < 7; i++) begin
      d = rand_vec();
      in_valid = pat[i];
      in_data  = d;
      @(negedge clk);
      if (pat[i]) begin
        fires++;
        for (int k = 0; k < N; k++) ref_sum[k] += longint'($signed(d[DW*k +: DW]));
      end
      checks++;
      if (pass_cnt !== PCW'(fires % NP)) begin
        errors++;
        $display("FAIL bubble_pass_cnt step=%0d got %0d expected %0d", i, pass_cnt, fires % NP);
      end
    end
    in_valid = 1'b0;
    wait_valid(cyc);
    checks++; if (out_data !== model(b, 1'b1)) begin errors++; $display("FAIL bubble_relu got %h expected %h", out_data, model(b, 1'b1)); end
    checks++; if (out_data_nr !== model(b, 1'b0)) begin errors++; $display("FAIL bubble_norelu got %h expected %h", out_data_nr, model(b, 1'b0)); end
    drain();
  endtask

  task automatic test_reset_mid();
    int cyc;
    clear_ref();
    feed(rand_vec());
    feed(rand_vec());
    checks++; if (pass_cnt !== PCW'(2)) begin errors++; $display("FAIL rstmid_pre pass_cnt=%0d expected 2", pass_cnt); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || pass_cnt !== '0 || out_data !== '0) begin errors++; $display("FAIL rstmid_clear out_valid=%0b pass_cnt=%0d out_data=%h expected all 0", out_valid, pass_cnt, out_data); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_ref();
    bias = '0;
    for (int i = 0; i < NP; i++) feed(rep(10));
    wait_valid(cyc);
    checks++; if (out_data !== rep(40)) begin errors++; $display("FAIL rstmid_fresh got %h expected %h", out_data, rep(40)); end
    // Reset while an output is pending drops it.
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== '0) begin errors++; $display("FAIL rsthold_clear out_valid=%0b out_data=%h expected 0/0", out_valid, out_data); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [W-1:0] fb;
    int cyc;
    for (int v = 0; v < 25; v++) begin
      clear_ref();
      fb = rand_vec();
      for (int i = 0; i < NP; i++) begin
        bias = rand_vec();
        repeat ($urandom_range(0, 2)) @(negedge clk);
        feed(rand_vec());
      end
      bias = fb;
      wait_valid(cyc);
      checks++; if (cyc !== 1) begin errors++; $display("FAIL rand_latency vec=%0d cycles=%0d expected 1", v, cyc); end
      bias = rand_vec();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      checks++; if (out_data !== model(fb, 1'b1)) begin errors++; $display("FAIL rand_relu vec=%0d got %h expected %h", v, out_data, model(fb, 1'b1)); end
      checks++; if (out_data_nr !== model(fb, 1'b0)) begin errors++; $display("FAIL rand_norelu vec=%0d got %h expected %h", v, out_data_nr, model(fb, 1'b0)); end
      drain();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu();
    test_saturation();
    test_backpressure();
    test_bubbles();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
